// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: steers the hps_io ioctl byte stream into up to four
// contiguous ROM regions and holds the core in reset until a clean load completes.
module rom_dl_ctrl #(
    parameter logic [16:0] R1_BASE     = 17'h0A000,
    parameter logic [16:0] R2_BASE     = 17'h0C000,
    parameter logic [16:0] R3_BASE     = 17'h0E000,
    parameter logic [16:0] TOTAL_SIZE  = 17'h10000,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [3:0]  dn_we,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_error,
    output logic [15:0] dl_sum
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_WAIT,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [16:0]         cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [15:0]         sum_q, sum_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                core_rst_q, core_rst_d;
    logic [3:0]          we_q, we_d;
    logic [16:0]         addr_q, addr_d;
    logic [7:0]          data_q, data_d;

    logic                in_range_c;
    logic                start_load_c;
    logic [3:0]          region_c;
    logic [16:0]         base_c;
    logic [16:0]         addr_lo_c;

    // Region decode of the incoming byte address
    always_comb begin
        addr_lo_c  = ioctl_addr[16:0];
        in_range_c = (ioctl_addr[24:17] == 8'd0) && (addr_lo_c < TOTAL_SIZE);
        if (addr_lo_c < R1_BASE) begin
            region_c = 4'b0001;
            base_c   = 17'd0;
        end else if (addr_lo_c < R2_BASE) begin
            region_c = 4'b0010;
            base_c   = R1_BASE;
        end else if (addr_lo_c < R3_BASE) begin
            region_c = 4'b0100;
            base_c   = R2_BASE;
        end else begin
            region_c = 4'b1000;
            base_c   = R3_BASE;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        sum_d        = sum_q;
        err_d        = err_q;
        done_d       = done_q;
        we_d         = 4'b0000;
        addr_d       = addr_q;
        data_d       = data_q;
        start_load_c = 1'b0;

        case (state_q)
            S_WAIT, S_RUN: begin
                if (ioctl_download) start_load_c = 1'b1;
            end
            S_LOAD: begin
                if (ioctl_wr) begin
                    cnt_d = cnt_q + 17'd1;
                    sum_d = sum_q + 16'(ioctl_dout);
                    if (ioctl_addr != {8'd0, cnt_q}) err_d = 1'b1;
                    if (!in_range_c) begin
                        err_d = 1'b1;
                    end else begin
                        we_d   = region_c;
                        addr_d = addr_lo_c - base_c;
                        data_d = ioctl_dout;
                    end
                end
                if (!ioctl_download) state_d = S_CHECK;
            end
            S_CHECK: begin
                if ((cnt_q != TOTAL_SIZE) || err_q) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ioctl_download) begin
                    start_load_c = 1'b1;
                end else if (hold_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = S_WAIT;
        endcase

        // Entering LOAD wipes the status of the previous download
        if (start_load_c) begin
            state_d = S_LOAD;
            cnt_d   = 17'd0;
            sum_d   = 16'd0;
            err_d   = 1'b0;
            done_d  = 1'b0;
        end

        core_rst_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_WAIT;
            cnt_q      <= 17'd0;
            hold_q     <= '0;
            sum_q      <= 16'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            we_q       <= 4'b0000;
            addr_q     <= 17'd0;
            data_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            sum_q      <= sum_d;
            err_q      <= err_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign dn_we      = we_q;
    assign dn_addr    = addr_q;
    assign dn_data    = data_q;
    assign core_reset = core_rst_q;
    assign dl_done    = done_q;
    assign dl_error   = err_q;
    assign dl_sum     = sum_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Scoreboard bench for rom_dl_ctrl; runs a scaled-down region map (same shape,
// 1/16 size) so full clean loads and reloads fit in a short simulation.
module tb_rom_dl_ctrl;

    localparam logic [16:0] T_R1    = 17'h00A00;
    localparam logic [16:0] T_R2    = 17'h00C00;
    localparam logic [16:0] T_R3    = 17'h00E00;
    localparam logic [16:0] T_TOTAL = 17'h01000;
    localparam int unsigned T_HOLD  = 16;

    typedef struct packed {
        logic [3:0]  we;
        logic [16:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk_sys;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic [3:0]  dn_we;
    logic        core_reset;
    logic        dl_done;
    logic        dl_error;
    logic [15:0] dl_sum;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          n_checks;
    int          n_errors;
    logic [15:0] sum_m;

    rom_dl_ctrl #(
        .R1_BASE    (T_R1),
        .R2_BASE    (T_R2),
        .R3_BASE    (T_R3),
        .TOTAL_SIZE (T_TOTAL),
        .HOLD_CYCLES(T_HOLD)
    ) u_dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_we         (dn_we),
        .core_reset    (core_reset),
        .dl_done       (dl_done),
        .dl_error      (dl_error),
        .dl_sum        (dl_sum)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write strobes are compared in order against what the stimulus predicted
    always @(negedge clk_sys) begin
        if (dn_we !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_we", 32'(dn_we), 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_eq("strobe", 32'({dn_we, dn_addr, dn_data}), 32'(sb_e));
            end
        end
    end

    function automatic exp_t model_strobe(input logic [16:0] a, input logic [7:0] d);
        exp_t e;
        e.data = d;
        if (a < T_R1) begin
            e.we = 4'b0001; e.addr = a;
        end else if (a < T_R2) begin
            e.we = 4'b0010; e.addr = a - T_R1;
        end else if (a < T_R3) begin
            e.we = 4'b0100; e.addr = a - T_R2;
        end else begin
            e.we = 4'b1000; e.addr = a - T_R3;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] we, input logic [16:0] a, input logic [7:0] d);
        exp_t e;
        e.we = we; e.addr = a; e.data = d;
        sb_q.push_back(e);
    endtask

    // Raise download with a stray write in the transition cycle, which must be ignored
    task automatic start_load();
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'hAA;
        tick();
        ioctl_wr = 1'b0;
        sum_m    = 16'd0;
    endtask

    // Sequential bytes data=addr[7:0]; download falls together with the last write
    task automatic load_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) ioctl_download = 1'b0;
            sb_q.push_back(model_strobe(17'(i), 8'(i)));
            sum_m = sum_m + 16'(8'(i));
            wr_byte(25'(i), 8'(i));
        end
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 50) begin
            tick();
            c++;
        end
        check_eq(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic finish_good(input string tag);
        int c;
        c = 0;
        while (core_reset && c < 64) begin
            tick();
            c++;
        end
        check_eq({tag, "_release_lat"}, 32'(c), 32'(T_HOLD + 1));
        check_eq({tag, "_done"}, 32'(dl_done), 32'd1);
        check_eq({tag, "_error"}, 32'(dl_error), 32'd0);
        check_eq({tag, "_sum"}, 32'(dl_sum), 32'(sum_m));
        drain({tag, "_drain"});
    endtask

    logic [16:0] bnd_a  [7];
    logic [3:0]  bnd_we [7];
    logic [16:0] bnd_rel[7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        sum_m    = 16'd0;
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = 25'd0; ioctl_dout = 8'd0;
        bnd_a   = '{17'h009FF, 17'h00A00, 17'h00BFF, 17'h00C00, 17'h00DFF, 17'h00E00, 17'h00FFF};
        bnd_we  = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
        bnd_rel = '{17'h009FF, 17'h0, 17'h001FF, 17'h0, 17'h001FF, 17'h0, 17'h001FF};
        repeat (3) tick();

        check_eq("rst_core_reset", 32'(core_reset), 32'd1);
        check_eq("rst_we", 32'(dn_we), 32'd0);
        check_eq("rst_addr", 32'(dn_addr), 32'd0);
        check_eq("rst_data", 32'(dn_data), 32'd0);
        check_eq("rst_done", 32'(dl_done), 32'd0);
        check_eq("rst_error", 32'(dl_error), 32'd0);
        check_eq("rst_sum", 32'(dl_sum), 32'd0);
        reset = 1'b0;
        tick();

        // Clean load
        start_load();
        check_eq("load_core_reset", 32'(core_reset), 32'd1);
        load_bytes(int'(T_TOTAL));
        finish_good("clean");
        check_eq("clean_sum_const", 32'(dl_sum), 32'h0000F800);

        // Reload from RUN
        start_load();
        check_eq("reload_core_reset", 32'(core_reset), 32'd1);
        check_eq("reload_done", 32'(dl_done), 32'd0);
        check_eq("reload_sum_clr", 32'(dl_sum), 32'd0);
        load_bytes(int'(T_TOTAL));
        finish_good("reload");

        // Short load
        start_load();
        load_bytes(int'(T_TOTAL) / 2);
        tick();
        check_eq("short_error", 32'(dl_error), 32'd1);
        check_eq("short_done", 32'(dl_done), 32'd0);
        repeat (20) tick();
        check_eq("short_core_reset", 32'(core_reset), 32'd1);
        wr_byte(25'd0, 8'h11);
        tick();
        drain("short_drain");
        check_eq("short_wait_no_we", 32'(dn_we), 32'd0);

        // Out-of-order, out-of-range and boundary decode
        start_load();
        for (int i = 0; i < 3; i++) begin
            push_exp(4'b0001, 17'(i), 8'(i + 8'h30));
            wr_byte(25'(i), 8'(i + 8'h30));
        end
        check_eq("inorder_error", 32'(dl_error), 32'd0);
        push_exp(4'b0001, 17'd5, 8'h55);
        wr_byte(25'd5, 8'h55);
        check_eq("ooo_error", 32'(dl_error), 32'd1);
        wr_byte(25'h0001000, 8'h66);
        wr_byte(25'h0010000, 8'h77);
        wr_byte(25'h0020005, 8'h88);
        for (int i = 0; i < 7; i++) begin
            push_exp(bnd_we[i], bnd_rel[i], 8'(8'hC0 + i));
            wr_byte(25'(bnd_a[i]), 8'(8'hC0 + i));
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        drain("bnd_drain");
        check_eq("bnd_error", 32'(dl_error), 32'd1);
        check_eq("bnd_done", 32'(dl_done), 32'd0);
        check_eq("bnd_core_reset", 32'(core_reset), 32'd1);

        // Reset in the middle of a load with a write pending
        start_load();
        for (int i = 0; i < 3; i++) begin
            push_exp(4'b0001, 17'(i), 8'(i + 8'h40));
            wr_byte(25'(i), 8'(i + 8'h40));
        end
        ioctl_wr = 1'b1; ioctl_addr = 25'd3; ioctl_dout = 8'h99;
        reset = 1'b1;
        tick();
        check_eq("mid_rst_we", 32'(dn_we), 32'd0);
        check_eq("mid_rst_sum", 32'(dl_sum), 32'd0);
        check_eq("mid_rst_core_reset", 32'(core_reset), 32'd1);
        check_eq("mid_rst_error", 32'(dl_error), 32'd0);
        reset = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        wr_byte(25'd4, 8'h12);
        tick();
        drain("mid_rst_drain");
        check_eq("mid_rst_wait_core_reset", 32'(core_reset), 32'd1);
        check_eq("mid_rst_wait_sum", 32'(dl_sum), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_dl_ctrl.md
Name: rom_dl_ctrl

Overview:
- Sequences the HPS ROM download stream (ioctl_*) into the core's ROM regions, holds the core in reset during and after loading, and flags malformed downloads.
- Sits in emu between hps_io and burger_time.
- Replaces the direct ioctl_addr/ioctl_dout/ioctl_wr wiring and the ioctl_download term in the core reset.
- Decodes up to 4 contiguous regions and emits a registered one-hot write strobe plus a region-relative address.

Parameters:
- R1_BASE, 17'h0A000, first byte of region 1 (region 0 starts at 0)
- R2_BASE, 17'h0C000, first byte of region 2
- R3_BASE, 17'h0E000, first byte of region 3
- TOTAL_SIZE, 17'h10000, total expected bytes; region 3 ends at TOTAL_SIZE-1
- HOLD_CYCLES, 16, core_reset hold time after a good download (>=1)

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download window from hps_io
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- dn_addr  out  17  address relative to the selected region base
- dn_data  out  8  byte to write
- dn_we  out  4  one-hot region write strobe, one cycle wide
- core_reset  out  1  reset to burger_time (ORed with the user reset outside)
- dl_done  out  1  high once a download has finished without error
- dl_error  out  1  sticky error for the current/last download
- dl_sum  out  16  modulo-2^16 sum of accepted bytes

Behaviour:
- Reset values:
  - state=WAIT, core_reset=1, dn_we=0, dn_addr=0, dn_data=0
  - dl_done=0, dl_error=0, dl_sum=0
  - byte counter cnt=0, hold counter=0
- States:
  - WAIT: no ROM loaded yet; core_reset=1. On ioctl_download=1 -> LOAD.
  - LOAD: core_reset=1. On entry cycle: cnt, dl_sum, dl_error and dl_done clear. On ioctl_download=0 -> CHECK.
  - CHECK: one cycle. If cnt!=TOTAL_SIZE, set dl_error. If error -> WAIT, else -> HOLD with hold counter=HOLD_CYCLES-1.
  - HOLD: core_reset=1; counter decrements each cycle. At 0 -> RUN and dl_done=1.
  - RUN: core_reset=0. On ioctl_download=1 -> LOAD (reload mid-game is allowed; the core is reset again).
- Byte accept (LOAD only, ioctl_wr=1):
  - In-order check: ioctl_addr must equal cnt. If not, set dl_error; the byte is still written if its address is in range.
  - Range check: ioctl_addr>=TOTAL_SIZE, or ioctl_addr[24:17]!=0, sets dl_error with no strobe.
  - Region select: region 0 = [0,R1_BASE), 1 = [R1_BASE,R2_BASE), 2 = [R2_BASE,R3_BASE), 3 = [R3_BASE,TOTAL_SIZE).
  - Next cycle (latency 1): dn_we[region]=1, dn_addr=ioctl_addr-base (17-bit), dn_data=ioctl_dout.
  - Same edge: cnt+=1, dl_sum+=ioctl_dout, both wrapping.
  - dn_addr and dn_data hold their values when dn_we=0.
- ioctl_wr outside LOAD is ignored: no strobe, no counting. This includes the cycle ioctl_download rises, which is the LOAD transition cycle.
- A write in the same cycle ioctl_download falls is accepted and counted before CHECK evaluates.
- ioctl_download dropping back while in HOLD is a no-op. ioctl_download rising in HOLD restarts LOAD.
- Reset asserted mid-download: returns to WAIT immediately. Any strobe in flight is dropped: dn_we=0 on the next cycle.
- dl_error stays high until the next LOAD entry. After an error the block remains in WAIT with core_reset=1.

Test Plan:
- Clean load: reset, then TOTAL_SIZE=0x10000 sequential bytes, each data=addr[7:0]. Required:
  - dn_we[0] for addr 0..0x9FFF; dn_we[3] at 0xE000 with dn_addr=0x0000.
  - dl_sum=0x8000.
  - dl_done=1 and core_reset falling exactly HOLD_CYCLES+1 cycles after ioctl_download falls.
  - dl_error=0.
- Short load: stop at 0x8000 bytes. Required: dl_error=1, dl_done=0, core_reset stays 1, state WAIT.
- Out-of-order and out-of-range: write addr 5 when cnt=3 -> dl_error=1 and dn_we[0] pulses with dn_addr=5. Write addr 0x10000 -> no dn_we pulse.
- Boundary decode: single writes at 0x9FFF, 0xA000, 0xBFFF, 0xC000, 0xDFFF, 0xE000, 0xFFFF. Required dn_we/dn_addr: 0001/0x9FFF, 0010/0, 0010/0x1FFF, 0100/0, 0100/0x1FFF, 1000/0, 1000/0x1FFF.
- Reload from RUN: after a clean load, raise ioctl_download. Required: core_reset=1 on the next cycle, dl_done=0, counters cleared, and a second clean load completes.
- Reset mid-LOAD: assert reset with ioctl_wr pending. Required: next cycle dn_we=0, state WAIT, dl_sum=0, core_reset=1.
